window_fetch: RTL
=================

WINDOW_FETCH -- requirements
Module: window_fetch

Interface
REQ-001 SHALL have parameter IMG_W, default 150, unpadded image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 150, unpadded image height in pixels.
REQ-003 SHALL have parameter WIN, default 3, odd window side; PAD=(WIN-1)/2, padded width PW=IMG_W+2*PAD.
REQ-004 SHALL have port clk, input, 1 bit, sole clock, rising edge.
REQ-005 SHALL have port re_n, input, 1 bit, reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have port re_win, input, 1 bit, single-cycle fetch-request strobe from control_fsm.
REQ-007 SHALL have port pixcel, input, 15 bits, centre-pixel raster index, sampled with re_win.
REQ-008 SHALL have port mem_addr, output, 15 bits, padded-image memory read address.
REQ-009 SHALL have port mem_data, input, 8 bits, memory read data, valid exactly 1 cycle after mem_addr.
REQ-010 SHALL have port win_pix, output, 8 bits, streamed window pixel.
REQ-011 SHALL have port win_valid, output, 1 bit, win_pix qualifier.
REQ-012 SHALL have port win_last, output, 1 bit, marks the final window pixel.
REQ-013 SHALL have port wf, output, 1 bit, one-cycle window-fetched done pulse back to control_fsm.
REQ-014 SHALL have port busy, output, 1 bit, high from the cycle after an accepted re_win through the wf cycle.
REQ-015 SHALL have port err, output, 1 bit, sticky out-of-range flag.

Function
REQ-016 SHALL implement states IDLE, CALC, ADDR, DRAIN, DONE.
REQ-017 IDLE: re_win=1 with pixcel<IMG_W*IMG_H SHALL latch pixcel and go to CALC; otherwise SHALL stay in IDLE.
REQ-018 CALC, 1 cycle: SHALL compute base = (pixcel/IMG_W)*PW + (pixcel%IMG_W), then go to ADDR.
REQ-019 ADDR: SHALL issue mem_addr = base + r*PW + c for r=0..WIN-1 (outer) and c=0..WIN-1 (inner), one per cycle, WIN*WIN cycles.
REQ-020 After the last address, SHALL go to DRAIN for 1 cycle.
REQ-021 SHALL drive win_valid=1 and win_pix=mem_data in the cycle after each issued address, so the stream is WIN*WIN contiguous beats.
REQ-022 SHALL assert win_last with the WIN*WIN-th beat only.
REQ-023 DONE: SHALL pulse wf for exactly 1 cycle, the cycle after win_last, then return to IDLE.
REQ-024 Latency, re_win at cycle 0: first address at cycle 2, first beat at 3, win_last at WIN*WIN+2, wf at WIN*WIN+3.
REQ-025 SHALL ignore re_win while busy=1, with no queueing and no disturbance of the stream.
REQ-026 re_win with pixcel>=IMG_W*IMG_H SHALL set err, issue no addresses, and pulse wf 1 cycle later so control_fsm cannot hang.
REQ-027 SHALL hold mem_addr at its last value whenever no address is being issued.
REQ-028 The r/c counters SHALL wrap to 0 only at WIN-1 and SHALL never overflow for WIN<=15.
REQ-029 Address arithmetic SHALL be 15-bit unsigned; the last address for pixcel=IMG_W*IMG_H-1 SHALL equal PW*PW-1.

Reset
REQ-030 re_n=0 SHALL force IDLE immediately; mem_addr=0, win_pix=0, win_valid=0, win_last=0, wf=0, busy=0, err=0, counters=0.
REQ-031 Reset mid-stream SHALL abort the stream with no wf pulse; the first re_win after release SHALL be served normally.

Configuration
REQ-032 Macro WINDOW_FETCH_SUM_EN, when defined, SHALL add output win_sum, 16 bits, the sum of all beats of the current window, cleared in CALC and valid in the wf cycle.
REQ-033 Without WINDOW_FETCH_SUM_EN, win_sum and its adder SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 Package lce_pkg SHALL hold IMG_W, IMG_H, WIN, PAD, PW and the state enumeration shared with control_fsm.
REQ-035 The r/c counters and address adder SHALL be a sub-module wf_addr_gen; the FSM, data path and sum SHALL stay in window_fetch.

Verification
REQ-036 Scenario: re_win with pixcel=0 -> mem_addr sequence 0,1,2,152,153,154,304,305,306; wf at cycle 12.
REQ-037 Scenario: pixcel=22499 -> first address 22797, last address 23103, win_last at cycle 11.
REQ-038 Scenario: re_win again at cycle 5 of a fetch -> ignored, exactly 9 beats, one wf.
REQ-039 Scenario: pixcel=22500 -> err=1, no win_valid, wf at cycle 2.
REQ-040 Scenario: re_n low at cycle 6 -> all outputs 0 next edge, no wf; a new request after release completes.
REQ-041 Scenario (WINDOW_FETCH_SUM_EN): memory returns 10..18 -> win_sum=126 in the wf cycle.

Source files
------------

// File: rtl/lce_pkg.sv
`default_nettype none
// ============================================================================
// Module : lce_pkg
// Brief  : Image geometry and control state encoding shared with control_fsm.
// Rev    : 1.0  initial release
// ============================================================================
package lce_pkg;

  localparam int IMG_W = 150;
  localparam int IMG_H = 150;
  localparam int WIN   = 3;
  localparam int PAD   = (WIN - 1) / 2;
  localparam int PW    = IMG_W + 2 * PAD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    ADDR  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wf_addr_gen.sv
`default_nettype none
// ============================================================================
// Module : wf_addr_gen
// Brief  : Row/column window counters and the padded-image address adder.
// Rev    : 1.0  initial release
// ============================================================================
module wf_addr_gen #(
  parameter int WIN = lce_pkg::WIN,
  parameter int PW  = lce_pkg::PW
) (
  input  logic        clk,
  input  logic        re_n,
  input  logic        clear,
  input  logic        step,
  input  logic [14:0] base,
  output logic [14:0] next_addr,
  output logic        last
);

  localparam logic [3:0]  c_WIN_M1 = 4'(WIN - 1);
  localparam logic [14:0] c_PW     = 15'(PW);

  logic [3:0]  r_row;
  logic [3:0]  r_col;
  logic [14:0] r_row_off;

  logic        w_col_wrap;
  logic [3:0]  w_col_nxt;
  logic [3:0]  w_row_nxt;
  logic [14:0] w_off_nxt;

  // Counters describe the address currently on the bus; the adder looks one ahead.
  always_comb begin
    w_col_wrap = (r_col == c_WIN_M1);
    w_col_nxt  = w_col_wrap ? 4'd0 : r_col + 4'd1;
    w_row_nxt  = r_row;
    w_off_nxt  = r_row_off;
    if (w_col_wrap) begin
      if (r_row == c_WIN_M1) begin
        w_row_nxt = 4'd0;
        w_off_nxt = 15'd0;
      end else begin
        w_row_nxt = r_row + 4'd1;
        w_off_nxt = r_row_off + c_PW;
      end
    end
  end

  assign last      = w_col_wrap && (r_row == c_WIN_M1);
  assign next_addr = base + w_off_nxt + {11'd0, w_col_nxt};

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_row     <= 4'd0;
      r_col     <= 4'd0;
      r_row_off <= 15'd0;
    end else if (clear) begin
      r_row     <= 4'd0;
      r_col     <= 4'd0;
      r_row_off <= 15'd0;
    end else if (step) begin
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_row_off <= w_off_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_fetch.sv
`default_nettype none
// ============================================================================
// Module : window_fetch
// Brief  : Fetches a WINxWIN window around a centre pixel from padded memory
//          and streams it out. WINDOW_FETCH_SUM_EN adds the win_sum output.
// Rev    : 1.0  initial release
// ============================================================================
module window_fetch #(
  parameter int IMG_W = lce_pkg::IMG_W,
  parameter int IMG_H = lce_pkg::IMG_H,
  parameter int WIN   = lce_pkg::WIN
) (
  input  logic        clk,
  input  logic        re_n,
  input  logic        re_win,
  input  logic [14:0] pixcel,
  output logic [14:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [7:0]  win_pix,
  output logic        win_valid,
  output logic        win_last,
  output logic        wf,
  output logic        busy,
`ifdef WINDOW_FETCH_SUM_EN
  output logic [15:0] win_sum,
`endif
  output logic        err
);

  import lce_pkg::*;

  localparam int          c_PAD    = (WIN - 1) / 2;
  localparam int          c_PW     = IMG_W + 2 * c_PAD;
  localparam logic [14:0] c_IMG_W  = 15'(IMG_W);
  localparam logic [14:0] c_PW15   = 15'(c_PW);
  localparam logic [31:0] c_NPIX   = 32'(IMG_W * IMG_H);

  state_t      r_state;
  logic [14:0] r_pix;
  logic [14:0] r_base;
  logic [14:0] r_mem_addr;
  logic        r_win_valid;
  logic        r_win_last;
  logic        r_wf;
  logic        r_busy;
  logic        r_err;

  logic        w_in_range;
  logic [14:0] w_row;
  logic [14:0] w_col;
  logic [14:0] w_base;
  logic [14:0] w_gen_next;
  logic        w_gen_last;
  logic        w_gen_clear;
  logic        w_gen_step;

  assign w_in_range = ({17'd0, pixcel} < c_NPIX);

  // Unpadded raster index -> top-left corner of its window in the padded image.
  assign w_row  = r_pix / c_IMG_W;
  assign w_col  = r_pix % c_IMG_W;
  assign w_base = w_row * c_PW15 + w_col;

  assign w_gen_clear = (r_state != ADDR);
  assign w_gen_step  = (r_state == ADDR) && !w_gen_last;

  wf_addr_gen #(
    .WIN (WIN),
    .PW  (c_PW)
  ) u_addr_gen (
    .clk       (clk),
    .re_n      (re_n),
    .clear     (w_gen_clear),
    .step      (w_gen_step),
    .base      (r_base),
    .next_addr (w_gen_next),
    .last      (w_gen_last)
  );

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_state     <= IDLE;
      r_pix       <= 15'd0;
      r_base      <= 15'd0;
      r_mem_addr  <= 15'd0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_wf        <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
      r_wf        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (re_win) begin
            r_busy <= 1'b1;
            if (w_in_range) begin
              r_pix   <= pixcel;
              r_state <= CALC;
            end else begin
              // Bad index still answers with wf so the requester never stalls.
              r_err   <= 1'b1;
              r_state <= DRAIN;
            end
          end
        end
        CALC: begin
          r_base     <= w_base;
          r_mem_addr <= w_base;
          r_state    <= ADDR;
        end
        ADDR: begin
          r_win_valid <= 1'b1;
          if (w_gen_last) begin
            r_win_last <= 1'b1;
            r_state    <= DRAIN;
          end else begin
            r_mem_addr <= w_gen_next;
          end
        end
        DRAIN: begin
          r_wf    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WINDOW_FETCH_SUM_EN
  logic [15:0] r_sum;

  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      r_sum <= 16'd0;
    end else if (r_state == CALC) begin
      r_sum <= 16'd0;
    end else if (r_win_valid) begin
      r_sum <= r_sum + {8'd0, mem_data};
    end
  end

  assign win_sum = r_sum;
`endif

  assign mem_addr  = r_mem_addr;
  assign win_pix   = r_win_valid ? mem_data : 8'd0;
  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;
  assign wf        = r_wf;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule
`default_nettype wire
